// File: rtl/nlprg_pkg.sv
// Shared constants and default feedback masks for the nlprg_n generator family.
package nlprg_pkg;

  localparam int NLPRG_NMIN = 3;
  localparam int NLPRG_NMAX = 32;

  // Maximal-length feedback masks: bit i set means state bit s[i] feeds back.
  // Each entry is a primitive polynomial of degree n, so the top bit is always
  // present and the step function stays invertible.
  function automatic logic [31:0] nlprg_taps(input int n);
    logic [31:0] t;
    t = 32'h0;
    case (n)
      3:  t = 32'h0000_0006;
      4:  t = 32'h0000_000C;
      5:  t = 32'h0000_0014;
      6:  t = 32'h0000_0030;
      7:  t = 32'h0000_0060;
      8:  t = 32'h0000_00B8;
      9:  t = 32'h0000_0110;
      10: t = 32'h0000_0240;
      11: t = 32'h0000_0500;
      12: t = 32'h0000_0829;
      13: t = 32'h0000_100D;
      14: t = 32'h0000_2015;
      15: t = 32'h0000_6000;
      16: t = 32'h0000_D008;
      17: t = 32'h0001_2000;
      18: t = 32'h0002_0400;
      19: t = 32'h0004_0023;
      20: t = 32'h0009_0000;
      21: t = 32'h0014_0000;
      22: t = 32'h0030_0000;
      23: t = 32'h0042_0000;
      24: t = 32'h00E1_0000;
      25: t = 32'h0120_0000;
      26: t = 32'h0200_0023;
      27: t = 32'h0400_0013;
      28: t = 32'h0900_0000;
      29: t = 32'h1400_0000;
      30: t = 32'h2000_0029;
      31: t = 32'h4800_0000;
      32: t = 32'h8020_0003;
      default: t = 32'h0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/nlprg_n_step.sv
// Combinational next-state function: Fibonacci shift with de Bruijn zero insertion.
module nlprg_step #(
  parameter int            N        = 14,
  parameter logic [N-1:0]  TAPS_EFF = '0
) (
  input  logic [N-1:0] i_s,
  output logic [N-1:0] o_s_next
);

  logic w_fb;

  // Flipping feedback when the low N-1 bits are zero splices the all-zero
  // state in between 100..0 and 0..01, stretching the period to 2^N.
  assign w_fb     = (^(i_s & TAPS_EFF)) ^ (i_s[N-2:0] == '0);
  assign o_s_next = {i_s[N-2:0], w_fb};

endmodule

// File: rtl/nlprg_n.sv
// Full-period nonlinear PRNG with seed load, wrap strobe and period self-check.
module nlprg_n
  import nlprg_pkg::*;
#(
  parameter int           N    = 14,
  parameter logic [N-1:0] TAPS = '0
) (
  input  logic         ck,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] seed,
  output logic [N-1:0] o,
  output logic         wrap,
  output logic         armed,
  output logic         err
);

  if (N < NLPRG_NMIN || N > NLPRG_NMAX) begin : g_bad_n
    $error("nlprg_n: N=%0d outside supported range %0d..%0d", N, NLPRG_NMIN, NLPRG_NMAX);
  end

  localparam logic [31:0]  TAPS_DEF = nlprg_taps(N);
  localparam logic [N-1:0] TAPS_EFF = (TAPS != '0) ? TAPS : TAPS_DEF[N-1:0];

  logic [N-1:0] r_s;
  logic [N-1:0] r_cnt;
  logic         r_armed;
  logic         r_err;
  logic         r_wrap;

  logic [N-1:0] w_s_next;
  logic         w_next_zero;
  logic         w_cnt_last;

  nlprg_step #(
    .N        (N),
    .TAPS_EFF (TAPS_EFF)
  ) u_step (
    .i_s      (r_s),
    .o_s_next (w_s_next)
  );

  assign w_next_zero = (w_s_next == '0);
  assign w_cnt_last  = (r_cnt == {N{1'b1}});

  // State register: load beats step, otherwise hold.
  always_ff @(posedge ck or posedge rst) begin
    if (rst)       r_s <= '0;
    else if (load) r_s <= seed;
    else if (en)   r_s <= w_s_next;
  end

  // Period checker: cnt counts steps since the last visit to 0. Once synced
  // to 0, a return to 0 must coincide exactly with cnt reaching its maximum;
  // any disagreement either way latches err until rst or load.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_armed <= 1'b1;
      r_err   <= 1'b0;
    end else if (load) begin
      r_cnt   <= '0;
      r_armed <= (seed == '0);
      r_err   <= 1'b0;
    end else if (en) begin
      if (r_armed && (w_next_zero != w_cnt_last)) r_err <= 1'b1;
      if (w_next_zero) begin
        r_cnt   <= '0;
        r_armed <= 1'b1;
      end else begin
        r_cnt   <= r_cnt + N'(1);
      end
    end
  end

  // Wrap strobe: high for the one cycle after a step lands on 0.
  always_ff @(posedge ck or posedge rst) begin
    if (rst)       r_wrap <= 1'b0;
    else if (load) r_wrap <= 1'b0;
    else if (en)   r_wrap <= w_next_zero;
    else           r_wrap <= 1'b0;
  end

  assign o     = r_s;
  assign wrap  = r_wrap;
  assign armed = r_armed;
  assign err   = r_err;

endmodule

// File: tb/tb_nlprg_n.sv
// Bench for nlprg_n: three instances (N=4 default taps, N=4 non-primitive
// taps, N=14 default taps) compared every cycle against a behavioural model,
// plus directed literal expectations.
module tb_nlprg_n;

  logic ck;
  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  // N=4 pair shares stimulus
  logic       rst, en, load;
  logic [3:0] seed;
  logic [3:0] oa, ob;
  logic       wa, aa, ea, wb, ab, eb;
  // N=14 instance
  logic        c_rst, c_en, c_load;
  logic [13:0] c_seed, oc;
  logic        wc, ac, ec;

  nlprg_n #(.N(4)) dut_a (
    .ck(ck), .rst(rst), .en(en), .load(load), .seed(seed),
    .o(oa), .wrap(wa), .armed(aa), .err(ea));

  nlprg_n #(.N(4), .TAPS(4'b1010)) dut_b (
    .ck(ck), .rst(rst), .en(en), .load(load), .seed(seed),
    .o(ob), .wrap(wb), .armed(ab), .err(eb));

  nlprg_n #(.N(14)) dut_c (
    .ck(ck), .rst(c_rst), .en(c_en), .load(c_load), .seed(c_seed),
    .o(oc), .wrap(wc), .armed(ac), .err(ec));

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // ---------------- behavioural model ----------------
  // Tap masks derived from the polynomials: x^4+x^3+1, the non-primitive
  // 4'b1010, and x^14+x^5+x^3+x+1.
  int          m_n[3]    = '{4, 4, 14};
  logic [31:0] m_taps[3] = '{32'h0000_000C, 32'h0000_000A, 32'h0000_2015};
  logic [31:0] m_s[3], m_cnt[3];
  bit          m_wrap[3], m_armed[3], m_err[3];

  function automatic logic [31:0] msk(input int n);
    return (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
  endfunction

  function automatic logic [31:0] nxt(input logic [31:0] s, input int n, input logic [31:0] t);
    logic fb;
    fb = (^(s & t)) ^ ((s & (msk(n) >> 1)) == 32'd0);
    return ((s << 1) | {31'd0, fb}) & msk(n);
  endfunction

  task automatic mreset(input int k);
    m_s[k] = 0; m_cnt[k] = 0; m_armed[k] = 1'b1; m_wrap[k] = 1'b0; m_err[k] = 1'b0;
  endtask

  task automatic mclk(input int k, input bit e, input bit l, input logic [31:0] sd);
    logic [31:0] nx;
    if (l) begin
      m_s[k] = sd; m_cnt[k] = 0; m_armed[k] = (sd == 0); m_err[k] = 1'b0; m_wrap[k] = 1'b0;
    end else if (e) begin
      nx = nxt(m_s[k], m_n[k], m_taps[k]);
      if (m_armed[k]) begin
        if (nx == 0 && m_cnt[k] != msk(m_n[k])) m_err[k] = 1'b1;
        if (nx != 0 && m_cnt[k] == msk(m_n[k])) m_err[k] = 1'b1;
      end
      if (nx == 0) begin
        m_cnt[k] = 0; m_armed[k] = 1'b1;
      end else begin
        m_cnt[k] = (m_cnt[k] + 1) & msk(m_n[k]);
      end
      m_s[k] = nx; m_wrap[k] = (nx == 0);
    end else begin
      m_wrap[k] = 1'b0;
    end
  endtask

  always @(posedge ck or posedge rst) begin
    if (rst) begin
      mreset(0); mreset(1);
    end else begin
      mclk(0, en, load, {28'd0, seed});
      mclk(1, en, load, {28'd0, seed});
    end
  end

  always @(posedge ck or posedge c_rst) begin
    if (c_rst) mreset(2);
    else       mclk(2, c_en, c_load, {18'd0, c_seed});
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // compare process, away from the active edge
  always @(negedge ck) begin
    if (chk_on) begin
      chk("a.o", {28'd0, oa}, m_s[0]);  chk("a.wrap", {31'd0, wa}, {31'd0, m_wrap[0]});
      chk("a.armed", {31'd0, aa}, {31'd0, m_armed[0]}); chk("a.err", {31'd0, ea}, {31'd0, m_err[0]});
      chk("b.o", {28'd0, ob}, m_s[1]);  chk("b.wrap", {31'd0, wb}, {31'd0, m_wrap[1]});
      chk("b.armed", {31'd0, ab}, {31'd0, m_armed[1]}); chk("b.err", {31'd0, eb}, {31'd0, m_err[1]});
      chk("c.o", {18'd0, oc}, m_s[2]);  chk("c.wrap", {31'd0, wc}, {31'd0, m_wrap[2]});
      chk("c.armed", {31'd0, ac}, {31'd0, m_armed[2]}); chk("c.err", {31'd0, ec}, {31'd0, m_err[2]});
    end
  end

  // one step: inputs change 2 time units after the rising edge
  task automatic tick();
    @(posedge ck);
    #2;
  endtask

  int seq4[17] = '{0, 1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8, 0};
  bit seen[16384];
  int ndist, nwrap;

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; seed = 4'd0;
    c_rst = 1'b1; c_en = 1'b0; c_load = 1'b0; c_seed = 14'd0;
    repeat (2) @(posedge ck);
    #2;
    rst = 1'b0; c_rst = 1'b0;
    #1;
    chk_on = 1'b1;
    // reset state
    chk("rst.o", {28'd0, oa}, 0);      chk("rst.armed", {31'd0, aa}, 1);
    chk("rst.wrap", {31'd0, wa}, 0);   chk("rst.err", {31'd0, ea}, 0);
    chk("rst.c.o", {18'd0, oc}, 0);

    // N=4 full period from reset
    en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("seq4.o", {28'd0, oa}, seq4[i]);
      chk("seq4.wrap", {31'd0, wa}, (i == 16) ? 1 : 0);
    end
    chk("seq4.err", {31'd0, ea}, 0);
    chk("badtaps.err_by16", {31'd0, eb}, 1);
    for (int i = 0; i < 16; i++) tick();
    chk("seq4.err32", {31'd0, ea}, 0);
    chk("badtaps.sticky", {31'd0, eb}, 1);

    // load with en also high: load wins
    load = 1'b1; seed = 4'd5;
    tick();
    load = 1'b0;
    chk("load.o", {28'd0, oa}, 5);
    chk("load.armed", {31'd0, aa}, 0);
    chk("badtaps.cleared", {31'd0, eb}, 0);
    // 5 -> 11,7,15,14,12,8,0
    for (int i = 0; i < 7; i++) tick();
    chk("seed5.o", {28'd0, oa}, 0);
    chk("seed5.wrap", {31'd0, wa}, 1);
    chk("seed5.armed", {31'd0, aa}, 1);

    // hold, then step, then load+en
    en = 1'b0;
    repeat (3) tick();
    chk("hold.o", {28'd0, oa}, 0);
    chk("hold.wrap", {31'd0, wa}, 0);
    en = 1'b1;
    tick();
    chk("resume.o", {28'd0, oa}, 1);
    load = 1'b1; seed = 4'd3;
    tick();
    load = 1'b0;
    chk("loaden.o", {28'd0, oa}, 3);
    tick();
    chk("loaden.step", {28'd0, oa}, 6);
    for (int i = 0; i < 32; i++) tick();
    chk("seed3.err", {31'd0, ea}, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      load = ($urandom_range(0, 15) == 0);
      seed = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      tick();
    end
    en = 1'b0; load = 1'b0;

    // asynchronous reset mid-run at o=9
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst.o", {28'd0, oa}, 9);
    rst = 1'b1;
    #1;
    chk("arst.o", {28'd0, oa}, 0);     chk("arst.wrap", {31'd0, wa}, 0);
    chk("arst.err", {31'd0, ea}, 0);   chk("arst.armed", {31'd0, aa}, 1);
    tick();
    rst = 1'b0;
    tick();
    chk("arst.restart", {28'd0, oa}, 1);
    en = 1'b0;

    // N=14: two full periods from reset
    nwrap = 0;
    c_en = 1'b1;
    for (int p = 0; p < 2; p++) begin
      ndist = 0;
      for (int k = 0; k < 16384; k++) seen[k] = 1'b0;
      for (int k = 1; k <= 16384; k++) begin
        tick();
        if (!seen[oc]) ndist++;
        seen[oc] = 1'b1;
        if (wc) nwrap++;
      end
      chk("n14.distinct", ndist, 16384);
      chk("n14.wrap_at_end", {31'd0, wc}, 1);
    end
    chk("n14.nwrap", nwrap, 2);
    chk("n14.err", {31'd0, ec}, 0);
    c_en = 1'b0;

    @(negedge ck);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
